// File: rtl/wb_ddr3_stream_bridge_if.sv
// Wishbone classic slave bus as seen by the DDR3 stream bridge.
interface wb_ddr3_stream_bridge_if;
   logic        i_wbs_cyc;
   logic        i_wbs_stb;
   logic        i_wbs_we;
   logic [31:0] i_wbs_adr;
   logic [31:0] i_wbs_dat;
   logic [3:0]  i_wbs_sel;
   logic [31:0] o_wbs_dat;
   logic        o_wbs_ack;

   modport slave (
      input  i_wbs_cyc, i_wbs_stb, i_wbs_we, i_wbs_adr, i_wbs_dat, i_wbs_sel,
      output o_wbs_dat, o_wbs_ack
   );

   modport master (
      output i_wbs_cyc, i_wbs_stb, i_wbs_we, i_wbs_adr, i_wbs_dat, i_wbs_sel,
      input  o_wbs_dat, o_wbs_ack
   );
endinterface

// File: rtl/wb_ddr3_stream_bridge.sv
// Wishbone classic slave that streams one bus cycle into one contiguous
// ddr3_controller transaction through its ping-pong user FIFOs.
//
// state     | meaning
// IDLE      | no transaction; waiting for cyc&stb
// WR_ACQ    | write request up, waiting to own a write FIFO half
// WR_STREAM | pushing accepted beats into the owned write half
// WR_FLUSH  | cycle ended, holding write_en until the controller drains
// RD_ACQ    | read request up, waiting to own the read FIFO half
// RD_STREAM | popping the owned read half onto the bus
module wb_ddr3_stream_bridge #(
   parameter int          DDR_ADDR_WIDTH = 28,
   parameter int          READ_TIMEOUT   = 4096,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
   input  logic                      clk,
   input  logic                      rst,
   wb_ddr3_stream_bridge_if.slave    wb,
   output logic                      o_timeout,
   output logic [DDR_ADDR_WIDTH-1:0] address,
   output logic                      write_en,
   output logic                      read_en,
   output logic                      if_write_strobe,
   output logic [31:0]               if_write_data,
   input  logic [1:0]                if_write_ready,
   output logic [1:0]                if_write_activate,
   input  logic [23:0]               if_write_fifo_size,
   input  logic                      if_starved,
   input  logic                      of_read_ready,
   output logic                      of_read_activate,
   input  logic [23:0]               of_read_size,
   input  logic [31:0]               of_read_data,
   output logic                      of_read_strobe
);

   localparam int TMO_W = $clog2(READ_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(READ_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, WR_ACQ, WR_STREAM, WR_FLUSH, RD_ACQ, RD_STREAM
   } state_t;

   state_t state, state_nxt;

   logic [23:0]               wr_count, wr_count_nxt;
   logic [23:0]               rd_count, rd_count_nxt;
   logic [TMO_W-1:0]          tmo_cnt, tmo_cnt_nxt;
   logic [DDR_ADDR_WIDTH-1:0] address_nxt;
   logic                      write_en_nxt, read_en_nxt, timeout_nxt;
   logic                      wstb_nxt, rstb_nxt, ack_nxt, ract_nxt;
   logic [1:0]                wact_nxt;
   logic [31:0]               wdata_nxt, dat_nxt;

   logic cyc, accept, start;
   logic wr_acq_go, wr_beat, wr_last, flush_done;
   logic rd_state, rd_acq_go, rd_serve, rd_last, rd_pend, rd_tmo;
   logic unused_wb;

   assign unused_wb = ^{wb.i_wbs_sel, wb.i_wbs_adr[31:DDR_ADDR_WIDTH]};

   assign cyc        = wb.i_wbs_cyc;
   assign accept     = wb.i_wbs_cyc & wb.i_wbs_stb & ~wb.o_wbs_ack;
   assign start      = (state == IDLE) & cyc & wb.i_wbs_stb & ~write_en & ~read_en;
   assign wr_acq_go  = (state == WR_ACQ) & cyc & (if_write_activate == 2'b00)
                       & (if_write_ready != 2'b00);
   assign wr_beat    = (state == WR_STREAM) & accept;
   assign wr_last    = wr_beat & ((wr_count + 24'd1) == if_write_fifo_size);
   assign flush_done = (state == WR_FLUSH) & (if_write_activate == 2'b00)
                       & (if_write_ready == 2'b11) & if_starved;
   assign rd_state   = (state == RD_ACQ) | (state == RD_STREAM);
   assign rd_acq_go  = (state == RD_ACQ) & cyc & of_read_ready & ~of_read_activate;
   assign rd_serve   = (state == RD_STREAM) & accept & (rd_count < of_read_size);
   assign rd_last    = rd_serve & ((rd_count + 24'd1) == of_read_size);
   assign rd_pend    = rd_state & accept;
   assign rd_tmo     = rd_pend & ~rd_serve & (tmo_cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start) state_nxt = wb.i_wbs_we ? WR_ACQ : RD_ACQ;
         WR_ACQ:    if (!cyc) state_nxt = WR_FLUSH;
                    else if (wr_acq_go) state_nxt = WR_STREAM;
         WR_STREAM: if (!cyc) state_nxt = WR_FLUSH;
                    else if (wr_last) state_nxt = WR_ACQ;
         WR_FLUSH:  if (flush_done) state_nxt = IDLE;
         RD_ACQ:    if (!cyc) state_nxt = IDLE;
                    else if (rd_acq_go) state_nxt = RD_STREAM;
         RD_STREAM: if (!cyc) state_nxt = IDLE;
                    else if (rd_last) state_nxt = RD_ACQ;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      address_nxt  = address;
      write_en_nxt = write_en;
      read_en_nxt  = read_en;
      wact_nxt     = if_write_activate;
      ract_nxt     = of_read_activate;
      wdata_nxt    = if_write_data;
      dat_nxt      = wb.o_wbs_dat;
      timeout_nxt  = o_timeout;
      wr_count_nxt = wr_count;
      rd_count_nxt = rd_count;
      wstb_nxt     = 1'b0;
      rstb_nxt     = 1'b0;
      ack_nxt      = 1'b0;
      tmo_cnt_nxt  = TMO_LOAD;
      if (rd_pend && !rd_serve && tmo_cnt != '0) tmo_cnt_nxt = tmo_cnt - TMO_W'(1);
      case (state)
         IDLE: if (start) begin
            address_nxt = wb.i_wbs_adr[DDR_ADDR_WIDTH-1:0];
            if (wb.i_wbs_we) write_en_nxt = 1'b1;
            else             read_en_nxt  = 1'b1;
         end
         WR_ACQ: if (wr_acq_go) begin
            wact_nxt     = if_write_ready[0] ? 2'b01 : 2'b10;
            wr_count_nxt = '0;
         end
         WR_STREAM: begin
            if (!cyc) begin
               if (wr_count != '0) wact_nxt = 2'b00;
            end else if (wr_beat) begin
               wdata_nxt    = wb.i_wbs_dat;
               wstb_nxt     = 1'b1;
               ack_nxt      = 1'b1;
               wr_count_nxt = wr_count + 24'd1;
               if (wr_last) wact_nxt = 2'b00;
            end
         end
         // A half acquired but never written is handed back here as well.
         WR_FLUSH: begin
            wact_nxt = 2'b00;
            if (flush_done) write_en_nxt = 1'b0;
         end
         RD_ACQ, RD_STREAM: begin
            if (!cyc) begin
               ract_nxt    = 1'b0;
               read_en_nxt = 1'b0;
            end else begin
               if (rd_acq_go) begin
                  ract_nxt     = 1'b1;
                  rd_count_nxt = '0;
               end
               if (rd_serve) begin
                  dat_nxt      = of_read_data;
                  rstb_nxt     = 1'b1;
                  ack_nxt      = 1'b1;
                  rd_count_nxt = rd_count + 24'd1;
                  if (rd_last) ract_nxt = 1'b0;
               end
               if (rd_tmo) begin
                  dat_nxt     = TIMEOUT_DATA;
                  ack_nxt     = 1'b1;
                  timeout_nxt = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         address           <= '0;
         write_en          <= 1'b0;
         read_en           <= 1'b0;
         if_write_activate <= 2'b00;
         of_read_activate  <= 1'b0;
         if_write_data     <= '0;
         if_write_strobe   <= 1'b0;
         of_read_strobe    <= 1'b0;
         wb.o_wbs_dat      <= '0;
         wb.o_wbs_ack      <= 1'b0;
         o_timeout         <= 1'b0;
         wr_count          <= '0;
         rd_count          <= '0;
         tmo_cnt           <= '0;
      end else begin
         address           <= address_nxt;
         write_en          <= write_en_nxt;
         read_en           <= read_en_nxt;
         if_write_activate <= wact_nxt;
         of_read_activate  <= ract_nxt;
         if_write_data     <= wdata_nxt;
         if_write_strobe   <= wstb_nxt;
         of_read_strobe    <= rstb_nxt;
         wb.o_wbs_dat      <= dat_nxt;
         wb.o_wbs_ack      <= ack_nxt;
         o_timeout         <= timeout_nxt;
         wr_count          <= wr_count_nxt;
         rd_count          <= rd_count_nxt;
         tmo_cnt           <= tmo_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_wb_ddr3_stream_bridge.sv
// Bench for wb_ddr3_stream_bridge: a behavioural ddr3_controller FIFO model
// plus table, random and hand-written Wishbone cycles.
module tb_wb_ddr3_stream_bridge;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        o_timeout, write_en, read_en;
   logic [27:0] address;
   logic        if_write_strobe, of_read_activate, of_read_strobe;
   logic [31:0] if_write_data;
   logic [1:0]  if_write_activate;
   logic [1:0]  if_write_ready = 2'b00;
   logic [23:0] if_write_fifo_size = 24'd64;
   logic        if_starved = 1'b0;
   logic        of_read_ready = 1'b0;
   logic [23:0] of_read_size = 24'd64;
   logic [31:0] of_read_data = '0;

   wb_ddr3_stream_bridge_if wb ();

   wb_ddr3_stream_bridge #(.DDR_ADDR_WIDTH(28), .READ_TIMEOUT(TMO), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst(rst), .wb(wb), .o_timeout(o_timeout), .address(address),
      .write_en(write_en), .read_en(read_en), .if_write_strobe(if_write_strobe),
      .if_write_data(if_write_data), .if_write_ready(if_write_ready),
      .if_write_activate(if_write_activate), .if_write_fifo_size(if_write_fifo_size),
      .if_starved(if_starved), .of_read_ready(of_read_ready),
      .of_read_activate(of_read_activate), .of_read_size(of_read_size),
      .of_read_data(of_read_data), .of_read_strobe(of_read_strobe)
   );

   always #5 clk = ~clk;

   // controller model knobs, driven by the stimulus process
   int          drain_lat = 2;
   bit          starve_block = 1'b0;
   bit          rd_avail = 1'b1;
   bit          wr_txn = 1'b0;
   logic [31:0] rd_base = '0;

   // controller model state, owned by the monitor
   int          drain [2] = '{0, 0};
   logic [1:0]  prev_act = 2'b00;
   int          ptr = 0;
   logic [31:0] wr_got [$];
   logic [1:0]  wr_half [$];
   int          rel_at [$];
   int          ack_viol = 0;
   int          both_viol = 0;

   int checks = 0;
   int errors = 0;

   always @(negedge clk) begin
      if (!rst) begin
         drain[0] = 0; drain[1] = 0; prev_act = 2'b00; ptr = 0;
      end else begin
         if (if_write_strobe) begin
            wr_got.push_back(if_write_data);
            wr_half.push_back(prev_act);
         end
         if (prev_act != 2'b00 && if_write_activate == 2'b00) rel_at.push_back(wr_got.size());
         if (wb.o_wbs_ack && wr_txn && prev_act == 2'b00) ack_viol++;
         for (int i = 0; i < 2; i++) begin
            if (prev_act[i] && !if_write_activate[i]) drain[i] = drain_lat;
            else if (drain[i] > 0) drain[i]--;
         end
         prev_act = if_write_activate;
         if (!read_en) ptr = 0;
         else if (of_read_strobe) ptr++;
      end
      if (write_en && read_en) both_viol++;
      for (int i = 0; i < 2; i++) if_write_ready[i] = !if_write_activate[i] && drain[i] == 0;
      if_starved    = (if_write_activate == 2'b00) && drain[0] == 0 && drain[1] == 0 && !starve_block;
      of_read_ready = read_en && rd_avail;
      of_read_data  = rd_base + 32'(ptr);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] wdata(input logic [31:0] b, input int k);
      return b ^ (32'(k + 1) * 32'h11);
   endfunction

   task automatic wait_ack(input int budget, output bit ok, output int waited);
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < budget) begin
         @(negedge clk);
         waited++;
         ok = wb.o_wbs_ack;
      end
   endtask

   task automatic run_txn(input string nm, input bit we, input logic [31:0] adr, input int n,
                          input int wsize, input int rsize, input logic [31:0] base,
                          input logic [27:0] exp_addr, input bit wait_flush, output int max_wait);
      bit ok;
      int waited, acks, bad, w0, r0;
      int exp_rel [$];
      logic [31:0] got_rd [$];
      logic [1:0] exp_half;
      acks = 0; bad = 0; max_wait = 0;
      if_write_fifo_size = 24'(wsize);
      of_read_size = 24'(rsize);
      rd_base = base;
      @(negedge clk);
      w0 = wr_got.size();
      r0 = rel_at.size();
      wr_txn = we;
      wb.i_wbs_cyc = 1'b1; wb.i_wbs_stb = 1'b1; wb.i_wbs_we = we;
      wb.i_wbs_adr = adr; wb.i_wbs_dat = wdata(base, 0); wb.i_wbs_sel = 4'hF;
      for (int k = 0; k < n; k++) begin
         wait_ack(600, ok, waited);
         if (!ok) begin
            chk({nm, "_ack_wait"}, 64'(ok), 64'd1);
            break;
         end
         if (k == 0) begin
            chk({nm, "_address"}, 64'(address), 64'(exp_addr));
            chk({nm, "_request"}, 64'(we ? write_en : read_en), 64'd1);
         end else if (waited > max_wait) max_wait = waited;
         got_rd.push_back(wb.o_wbs_dat);
         acks++;
         wb.i_wbs_dat = wdata(base, k + 1);
      end
      wb.i_wbs_cyc = 1'b0; wb.i_wbs_stb = 1'b0;
      chk({nm, "_acks"}, 64'(acks), 64'(n));
      if (!we) begin
         foreach (got_rd[k]) if (got_rd[k] !== base + 32'(k)) bad++;
         chk({nm, "_rd_data_bad"}, 64'(bad), 64'd0);
         @(negedge clk);
         chk({nm, "_rd_end"}, 64'({read_en, of_read_activate}), 64'd0);
      end else if (wait_flush) begin
         ok = 1'b0;
         for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            ok = !write_en;
         end
         chk({nm, "_flush_done"}, 64'(ok), 64'd1);
         chk({nm, "_flush_act"}, 64'(if_write_activate), 64'd0);
         chk({nm, "_words"}, 64'(wr_got.size() - w0), 64'(n));
         for (int k = 0; k < n && (w0 + k) < wr_got.size(); k++) begin
            exp_half = ((k / wsize) % 2 == 0) ? 2'b01 : 2'b10;
            if (wr_got[w0 + k] !== wdata(base, k) || wr_half[w0 + k] !== exp_half) bad++;
         end
         chk({nm, "_wr_order_bad"}, 64'(bad), 64'd0);
         for (int m = wsize; m <= n; m += wsize) exp_rel.push_back(m);
         if (n % wsize != 0) exp_rel.push_back(n);
         chk({nm, "_releases"}, 64'(rel_at.size() - r0), 64'(exp_rel.size()));
         bad = 0;
         foreach (exp_rel[i]) if (r0 + i >= rel_at.size() || rel_at[r0 + i] - w0 != exp_rel[i]) bad++;
         chk({nm, "_release_points_bad"}, 64'(bad), 64'd0);
      end
      wr_txn = 1'b0;
   endtask

   typedef struct {
      string       nm;
      bit          we;
      logic [31:0] adr;
      int          n;
      int          wsize;
      int          rsize;
      logic [31:0] base;
      logic [27:0] exp_addr;
   } vec_t;

   initial begin
      vec_t vecs [6];
      bit ok;
      int waited, mw;
      logic [31:0] radr;
      bit rwe;

      #100000000;
   end

   initial begin
      #600000;
      $display("FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [6];
      bit ok;
      int waited, mw;
      logic [31:0] radr;
      bit rwe;

      vecs[0] = '{"wr5",    1'b1, 32'h0000_0100, 5, 64, 64, 32'h0,  28'h000_0100};
      vecs[1] = '{"rd3",    1'b0, 32'h0000_2000, 3, 64, 64, 32'hA0, 28'h000_2000};
      vecs[2] = '{"wrfull", 1'b1, 32'hF123_4567, 4, 2,  64, 32'h5A5A_0000, 28'h123_4567};
      vecs[3] = '{"rdwrap", 1'b0, 32'hFFFF_FFFF, 5, 64, 2,  32'h1000, 28'hFFF_FFFF};
      vecs[4] = '{"wr1",    1'b1, 32'h0000_0000, 1, 1,  64, 32'hC0DE_0000, 28'h000_0000};
      vecs[5] = '{"rd1",    1'b0, 32'h0000_0010, 1, 64, 1,  32'h7700, 28'h000_0010};

      wb.i_wbs_cyc = 1'b0; wb.i_wbs_stb = 1'b0; wb.i_wbs_we = 1'b0;
      wb.i_wbs_adr = '0; wb.i_wbs_dat = '0; wb.i_wbs_sel = 4'h0;
      repeat (3) @(negedge clk);
      chk("reset_state", 64'(|{wb.o_wbs_ack, wb.o_wbs_dat, write_en, read_en, address, if_write_strobe,
                              if_write_activate, of_read_activate, of_read_strobe, o_timeout}), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i])
         run_txn(vecs[i].nm, vecs[i].we, vecs[i].adr, vecs[i].n, vecs[i].wsize, vecs[i].rsize,
                 vecs[i].base, vecs[i].exp_addr, 1'b1, mw);

      // 130 words over 64-word halves; a long drain forces a stall before the third half
      drain_lat = 150;
      run_txn("wr130", 1'b1, 32'h0000_8000, 130, 64, 64, 32'h0, 28'h000_8000, 1'b1, mw);
      chk("wr130_stalled", 64'(mw >= 10), 64'd1);
      drain_lat = 2;

      // read timeout with the read half never offered
      rd_avail = 1'b0;
      @(negedge clk);
      wb.i_wbs_cyc = 1'b1; wb.i_wbs_stb = 1'b1; wb.i_wbs_we = 1'b0; wb.i_wbs_adr = 32'h40;
      wait_ack(100, ok, waited);
      chk("tmo_ack", 64'(ok), 64'd1);
      chk("tmo_latency_in_range", 64'(waited >= TMO && waited <= TMO + 2), 64'd1);
      chk("tmo_data", 64'(wb.o_wbs_dat), 64'hDEADBEEF);
      chk("tmo_flag", 64'(o_timeout), 64'd1);
      wb.i_wbs_cyc = 1'b0; wb.i_wbs_stb = 1'b0;
      rd_avail = 1'b1;
      run_txn("rd_after_tmo", 1'b0, 32'h0000_0400, 2, 64, 64, 32'h300, 28'h000_0400, 1'b1, mw);
      chk("tmo_sticky", 64'(o_timeout), 64'd1);

      // reset asserted mid-write after 10 beats
      if_write_fifo_size = 24'd64;
      @(negedge clk);
      wr_txn = 1'b1;
      wb.i_wbs_cyc = 1'b1; wb.i_wbs_stb = 1'b1; wb.i_wbs_we = 1'b1;
      wb.i_wbs_adr = 32'h300; wb.i_wbs_dat = wdata(32'h0, 0);
      for (int k = 0; k < 10; k++) begin
         wait_ack(600, ok, waited);
         wb.i_wbs_dat = wdata(32'h0, k + 1);
      end
      chk("pre_rst_write_en", 64'(write_en), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst_async_outputs", 64'(|{wb.o_wbs_ack, wb.o_wbs_dat, write_en, read_en, address,
                                    if_write_strobe, if_write_activate, of_read_activate,
                                    of_read_strobe}), 64'd0);
      chk("rst_timeout_clear", 64'(o_timeout), 64'd0);
      wb.i_wbs_cyc = 1'b0; wb.i_wbs_stb = 1'b0;
      wr_txn = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_txn("wr_after_rst", 1'b1, 32'h0000_0500, 6, 4, 64, 32'h1234_0000, 28'h000_0500, 1'b1, mw);

      // write followed at once by a read while the controller is held non-starved
      starve_block = 1'b1;
      run_txn("b2b_wr", 1'b1, 32'h0000_0600, 4, 64, 64, 32'h0, 28'h000_0600, 1'b0, mw);
      chk("b2b_write_held", 64'(write_en), 64'd1);
      fork
         begin
            repeat (20) @(negedge clk);
            starve_block = 1'b0;
         end
      join_none
      run_txn("b2b_rd", 1'b0, 32'h0000_4000, 2, 64, 64, 32'hB0, 28'h000_4000, 1'b1, mw);

      // random cycles against the FIFO model
      for (int r = 0; r < 20; r++) begin
         rwe  = 1'($urandom_range(0, 1));
         radr = $urandom;
         drain_lat = $urandom_range(1, 4);
         run_txn($sformatf("rnd%0d", r), rwe, radr, $urandom_range(1, 24), $urandom_range(1, 8),
                 $urandom_range(1, 8), $urandom, radr[27:0], 1'b1, mw);
      end

      chk("no_ack_without_half", 64'(ack_viol), 64'd0);
      chk("no_read_during_write", 64'(both_viol), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
